// File: rtl/fixed_point_add_arbiter.sv
// fixed_point_add_arbiter: round-robin arbiter sharing one fixed-point adder among REQUESTERS clients
//
// fixed_point_add (helper): W-bit signed adder, wrapping or saturating.
// fixed_point_add_arbiter ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-client request valid
//   req_ready    per-client request accept, at most one bit high
//   req_a/req_b  client k operands in bits [k*W +: W], signed two's complement
//   resp_valid   one-hot response valid, addressed to the issuing client
//   resp_ready   per-client response accept (only the owner's bit matters)
//   resp_result  registered sum on a shared bus
// Optional feature: define FIXED_POINT_ADD_ARBITER_SATURATE_EN to saturate sums
// instead of wrapping.

module fixed_point_add #(
    parameter int INTEGER_PART_WIDTH    = 2,
    parameter int FRACTIONAL_PART_WIDTH = 1,
    localparam int W = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    logic [W-1:0] raw;
    assign raw = a + b;
`ifdef FIXED_POINT_ADD_ARBITER_SATURATE_EN
    logic ovf;
    // overflow only when operands share a sign and the sum flips it
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    assign sum = ovf ? {a[W-1], {(W-1){~a[W-1]}}} : raw;
`else
    assign sum = raw;
`endif
endmodule

module fixed_point_add_arbiter #(
    parameter int INTEGER_PART_WIDTH    = 2,
    parameter int FRACTIONAL_PART_WIDTH = 1,
    parameter int REQUESTERS            = 4,
    localparam int W  = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REQUESTERS-1:0]   req_valid,
    output logic [REQUESTERS-1:0]   req_ready,
    input  logic [REQUESTERS*W-1:0] req_a,
    input  logic [REQUESTERS*W-1:0] req_b,
    output logic [REQUESTERS-1:0]   resp_valid,
    input  logic [REQUESTERS-1:0]   resp_ready,
    output logic [W-1:0]            resp_result
);
    typedef enum logic {IDLE, RESP} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] ptr, owner, g, ptr_nxt;
    logic found, hs, accept;
    logic [W-1:0] sum;
    // first valid requester searching upward from ptr, wrapping
    always_comb begin
        found = 1'b0;
        g = ptr;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (!found && req_valid[(int'(ptr) + i) % REQUESTERS]) begin
                found = 1'b1;
                g = PW'((int'(ptr) + i) % REQUESTERS);
            end
        end
    end
    assign ptr_nxt = (g == PW'(REQUESTERS - 1)) ? '0 : g + 1'b1;
    fixed_point_add #(
        .INTEGER_PART_WIDTH(INTEGER_PART_WIDTH),
        .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
    ) u_add (
        .a(req_a[g*W +: W]),
        .b(req_b[g*W +: W]),
        .sum(sum)
    );
    // a held result may be replaced in the same cycle its owner takes it
    always_comb begin
        hs = (state == RESP) && resp_ready[owner];
        accept = found && (state == IDLE || hs);
        req_ready = accept ? REQUESTERS'(1) << g : '0;
        state_nxt = accept ? RESP : (hs ? IDLE : state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            owner <= '0;
            resp_valid <= '0;
            resp_result <= '0;
        end else if (accept) begin
            ptr <= ptr_nxt;
            owner <= g;
            resp_valid <= REQUESTERS'(1) << g;
            resp_result <= sum;
        end else if (hs) begin
            resp_valid <= '0;
        end
    end
endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// tb_fixed_point_add_arbiter: randomized and directed check of fixed_point_add_arbiter against a behavioural model
module tb_fixed_point_add_arbiter;
    localparam int R = 4;
    localparam int W = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [R-1:0] req_valid = '0;
    logic [R-1:0] resp_ready = '1;
    logic [R*W-1:0] req_a = '0;
    logic [R*W-1:0] req_b = '0;
    logic [R-1:0] req_ready, resp_valid;
    logic [W-1:0] resp_result;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;

    fixed_point_add_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result)
    );

    // model: is a result pending, for whom, what value, where the search starts
    logic m_busy;
    int m_owner, m_ptr, mg;
    logic [W-1:0] m_result;
    logic m_acc;

    function automatic int grant(input logic [R-1:0] v, input int p);
        for (int i = 0; i < R; i++) if (v[(p + i) % R]) return (p + i) % R;
        return -1;
    endfunction

    function automatic logic [W-1:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, s;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        s = sa + sb;
`ifdef FIXED_POINT_ADD_ARBITER_SATURATE_EN
        if (s > 3) s = 3;
        if (s < -4) s = -4;
`endif
        return W'(s & ((1 << W) - 1));
    endfunction

    always_comb begin
        mg = grant(req_valid, m_ptr);
        m_acc = (mg >= 0) && (!m_busy || resp_ready[m_owner]);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_owner <= 0;
            m_ptr <= 0;
            m_result <= '0;
        end else if (m_acc) begin
            m_busy <= 1'b1;
            m_owner <= mg;
            m_ptr <= (mg + 1) % R;
            m_result <= add_ref(req_a[mg*W +: W], req_b[mg*W +: W]);
        end else if (m_busy && resp_ready[m_owner]) begin
            m_busy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", 32'(req_ready), m_acc ? 32'(R'(1) << mg) : 32'd0);
            chk("resp_valid", 32'(resp_valid), m_busy ? 32'(R'(1) << m_owner) : 32'd0);
            chk("resp_result", 32'(resp_result), 32'(m_result));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    initial begin
        req_valid = '1;
        for (int k = 0; k < R; k++) set_op(k, W'(k), 3'b001);
        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", 32'(req_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("fair_valid", 32'(resp_valid), 32'(4'b0001 << (i % R)));
        end
        tick();
        req_valid = 4'b0100;
        set_op(2, 3'b001, 3'b010);
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_valid", 32'(resp_valid), 32'b0100);
        chk("single_result", 32'(resp_result), 32'b011);
        tick();
        set_op(0, 3'b011, 3'b001);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        @(negedge clk);
`ifdef FIXED_POINT_ADD_ARBITER_SATURATE_EN
        chk("ovf_pos", 32'(resp_result), 32'b011);
`else
        chk("ovf_pos", 32'(resp_result), 32'b100);
`endif
        tick();
        set_op(0, 3'b100, 3'b111);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        @(negedge clk);
`ifdef FIXED_POINT_ADD_ARBITER_SATURATE_EN
        chk("ovf_neg", 32'(resp_result), 32'b100);
`else
        chk("ovf_neg", 32'(resp_result), 32'b011);
`endif
        tick();
        resp_ready = '0;
        set_op(1, 3'b001, 3'b001);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", 32'(resp_result), 32'b010);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(resp_valid), 32'b0010);
            tick();
        end
        resp_ready = 4'b0010;
        @(negedge clk);
        chk("bp_release", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("bp_next", 32'(resp_valid), 32'b1000);
        tick();
        resp_ready = '1;
        tick();
        resp_ready = '0;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("mid_valid", 32'(resp_valid), 32'b0010);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 32'(resp_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        resp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_replay", 32'(resp_valid), 32'd0);
            tick();
        end
        for (int i = 0; i < 1500; i++) begin
            req_a = (R*W)'($urandom);
            req_b = (R*W)'($urandom);
            if ((i / 100) % 4 == 3) begin
                req_valid = '1;
                resp_ready = '1;
            end else begin
                req_valid = R'($urandom);
                resp_ready = ($urandom_range(0, 2) == 0) ? R'($urandom) : '1;
            end
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fixed_point_add_arbiter.md
# fixed_point_add_arbiter

Round-robin arbiter that shares one `fixed_point_add` datapath among `REQUESTERS` independent clients. Each client uses a valid/ready request channel and a valid/ready response channel. The block serialises operations through the single adder, registers the sum, and returns it to the client that issued the request. It sits between the plotter's expression-evaluation units and the shared adder.

## Interface
- `INTEGER_PART_WIDTH`, 2, integer bits of each operand/result
- `FRACTIONAL_PART_WIDTH`, 1, fractional bits of each operand/result
- `REQUESTERS`, 4, number of clients (≥2); W = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  REQUESTERS  per-client request valid
- `req_ready`  out  REQUESTERS  per-client request accept (at most one bit high)
- `req_a`  in  REQUESTERS*W  client k operand a in bits [k*W +: W], signed two's complement
- `req_b`  in  REQUESTERS*W  client k operand b in bits [k*W +: W]
- `resp_valid`  out  REQUESTERS  one-hot response valid, addressed to the issuing client
- `resp_ready`  in  REQUESTERS  per-client response accept
- `resp_result`  out  W  registered sum, shared bus, meaningful only where `resp_valid` is set

## Operation
- States: IDLE (no result held) and RESP (result held for client `owner`).
- Round-robin pointer `ptr` (clog2 REQUESTERS bits). Grant `g` = first k with `req_valid[k]`, searching from `ptr` upward and wrapping modulo REQUESTERS.
- `req_ready[g]` is high only when a grant exists and one of these holds:
  - the state is IDLE, or
  - the state is RESP and `resp_ready[owner]` is high in the same cycle (back-to-back).
- All other `req_ready` bits are 0. `req_ready` may depend combinationally on `req_valid` and `resp_ready`.
- Accept occurs when `req_valid[g] && req_ready[g]`. On accept:
  - `req_a` and `req_b` slice g drive the single adder instance.
  - The sum is registered into `resp_result`.
  - `owner` <= g, `resp_valid` <= one-hot(g), state <= RESP, `ptr` <= (g+1) mod REQUESTERS.
- In RESP, `resp_valid[owner]` and `resp_result` are held stable until `resp_ready[owner]` is high.
- On the handshake with no new accept in the same cycle: `resp_valid` <= 0 and state <= IDLE. `resp_result` keeps its last value.
- Arithmetic: W-bit signed add, wrapping modulo 2^W. There is no widening, and the binary point is unchanged.
- `resp_ready` bits of non-owner clients are ignored.
- A client may hold `req_valid` through its own pending response. It is re-granted only after the pointer passes it, or when it is the sole requester.

## Timing
- Reset values:
  - `req_ready` = 0, but its combinational term follows reset state, i.e. it can be 1 when a request is present.
  - `resp_valid` = 0, `resp_result` = 0, `ptr` = 0, `owner` = 0, state = IDLE.
- Latency: accept in cycle N gives `resp_valid` and `resp_result` valid from cycle N+1.
- Throughput: one operation per cycle when every response is accepted immediately (back-to-back path); otherwise one per two cycles.
- Simultaneous response handshake and new accept: the new result overwrites `resp_result` and `resp_valid` moves to the new owner in the same edge. If the new grant is the same client, `resp_valid` stays high.
- Reset mid-operation (rst_n low in RESP): the pending result is discarded immediately and asynchronously; it is not replayed.
- All requesters idle: the block remains in IDLE with `ptr` unchanged.

## Configuration
- `FIXED_POINT_ADD_ARBITER_SATURATE_EN`
  - Defined: the registered result saturates. Overflow is detected when a and b have equal sign bits and the sum's sign differs. Positive overflow yields 0 followed by all ones (max); negative overflow yields 1 followed by all zeros (min).
  - Undefined: wrapping add; the overflow logic is absent.

## Test plan
- Reset: hold rst_n low with req_valid=4'b1111 → resp_valid=0 and resp_result=0. Release → client 0 accepted first cycle; resp_valid=4'b0001 next cycle.
- Single add (defaults): client 2 issues a=3'b001 (0.5), b=3'b010 (1.0) → resp_valid=4'b0100 one cycle after accept, resp_result=3'b011 (1.5).
- Fairness: all four clients hold req_valid with resp_ready held high → grants occur in order 0,1,2,3,0 on consecutive cycles, one result per cycle, each result routed to its own resp_valid bit.
- Backpressure: client 1 holds resp_ready=0 for 5 cycles with client 3 requesting → resp_result stable, req_ready=0 throughout. resp_ready[1]=1 → client 3 accepted in that same cycle.
- Overflow: a=3'b011, b=3'b001 → 3'b100 without the macro; 3'b011 with `FIXED_POINT_ADD_ARBITER_SATURATE_EN`. Also a=3'b100, b=3'b111 → 3'b011 without the macro, 3'b100 with it.
- Reset mid-RESP: assert rst_n low while resp_valid=4'b0010 → resp_valid drops to 0 asynchronously. After release, no response is issued until a new request.
